// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter. It sends one command byte
// and runs the complete line sequence:
//   1. inhibit the clock;
//   2. request-to-send;
//   3. eleven device-clocked bits (data, parity, stop);
//   4. wait for the device acknowledge and for the bus to go idle.
// The byte ends with a done pulse after an ACK, or an error pulse after a
// NACK or a timeout.
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-low reset
//   tx_start      one-cycle request, accepted only while busy=0
//   tx_data[7:0]  command byte, latched on accept
//   ps2_clk_in    raw PS/2 clock line (asynchronous)
//   ps2_data_in   raw PS/2 data line (asynchronous)
//   ps2_clk_oe    1 = pull PS/2 clock low
//   ps2_data_oe   1 = pull PS/2 data low
//   busy          transaction in progress
//   tx_done       one-cycle pulse: byte acknowledged, bus idle
//   tx_error      one-cycle pulse: NACK or timeout
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 5000,   // must be >= 2
   parameter int unsigned TIMEOUT_CYCLES = 750000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       tx_done,
   output logic       tx_error
);

   localparam int unsigned TMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int unsigned TW   = $clog2(TMAX + 1);
   localparam logic [TW-1:0] INH_LAST  = TW'(INHIBIT_CYCLES - 1);
   localparam logic [TW-1:0] INH_START = TW'(INHIBIT_CYCLES - 2);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_INHIBIT, S_RTS, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE, S_ERROR
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    shift_q, shift_d;
   logic          parity_q, parity_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          clk_oe_q, clk_oe_d;
   logic          data_oe_q, data_oe_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          error_q, error_d;

   logic clk_meta_q, clk_sync_q, clk_prev_q;
   logic data_meta_q, data_sync_q;
   logic fe;
   logic fail;

   // Two-stage synchronizers. The extra clock stage gives the edge detector.
   // They reset to 1 because that is the idle level of the lines.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clk_meta_q  <= 1'b1;
         clk_sync_q  <= 1'b1;
         clk_prev_q  <= 1'b1;
         data_meta_q <= 1'b1;
         data_sync_q <= 1'b1;
      end else begin
         clk_meta_q  <= ps2_clk_in;
         clk_sync_q  <= clk_meta_q;
         clk_prev_q  <= clk_sync_q;
         data_meta_q <= ps2_data_in;
         data_sync_q <= data_meta_q;
      end
   end

   assign fe = clk_prev_q & ~clk_sync_q;

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      parity_d  = parity_q;
      bit_cnt_d = bit_cnt_q;
      timer_d   = timer_q;
      clk_oe_d  = clk_oe_q;
      data_oe_d = data_oe_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      error_d   = 1'b0;
      fail      = 1'b0;

      case (state_q)
         // ERROR is the single cycle carrying the error pulse. busy is
         // already low there, so a new request is accepted just as in IDLE.
         S_IDLE, S_ERROR: begin
            state_d   = S_IDLE;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            if (tx_start) begin
               shift_d   = tx_data;
               parity_d  = ~^tx_data;
               bit_cnt_d = '0;
               timer_d   = '0;
               clk_oe_d  = 1'b1;
               busy_d    = 1'b1;
               state_d   = S_INHIBIT;
            end
         end
         S_INHIBIT: begin
            timer_d = timer_q + 1'b1;
            // The start bit (data low) appears in the final inhibit cycle.
            if (timer_q == INH_START) data_oe_d = 1'b1;
            if (timer_q == INH_LAST) begin
               clk_oe_d = 1'b0;
               timer_d  = '0;
               state_d  = S_RTS;
            end
         end
         S_RTS: begin
            timer_d = fe ? '0 : timer_q + 1'b1;
            if (fe) begin
               data_oe_d = ~shift_q[0];
               shift_d   = shift_q >> 1;
               bit_cnt_d = '0;
               state_d   = S_DATA;
            end else if (timer_q == TO_LAST) begin
               fail = 1'b1;
            end
         end
         S_DATA: begin
            timer_d = fe ? '0 : timer_q + 1'b1;
            if (fe) begin
               if (bit_cnt_q == 3'd7) begin
                  data_oe_d = ~parity_q;
                  state_d   = S_PARITY;
               end else begin
                  data_oe_d = ~shift_q[0];
                  shift_d   = shift_q >> 1;
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end else if (timer_q == TO_LAST) begin
               fail = 1'b1;
            end
         end
         S_PARITY: begin
            timer_d = fe ? '0 : timer_q + 1'b1;
            if (fe) begin
               data_oe_d = 1'b0;
               state_d   = S_STOP;
            end else if (timer_q == TO_LAST) begin
               fail = 1'b1;
            end
         end
         S_STOP: begin
            timer_d = fe ? '0 : timer_q + 1'b1;
            if (fe) begin
               if (!data_sync_q) state_d = S_WAIT_IDLE;
               else              fail    = 1'b1;
            end else if (timer_q == TO_LAST) begin
               fail = 1'b1;
            end
         end
         S_WAIT_IDLE: begin
            timer_d = fe ? '0 : timer_q + 1'b1;
            if (clk_sync_q && data_sync_q) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else if (!fe && timer_q == TO_LAST) begin
               fail = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (fail) begin
         clk_oe_d  = 1'b0;
         data_oe_d = 1'b0;
         busy_d    = 1'b0;
         error_d   = 1'b1;
         state_d   = S_ERROR;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         shift_q   <= '0;
         parity_q  <= 1'b0;
         bit_cnt_q <= '0;
         timer_q   <= '0;
         clk_oe_q  <= 1'b0;
         data_oe_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         parity_q  <= parity_d;
         bit_cnt_q <= bit_cnt_d;
         timer_q   <= timer_d;
         clk_oe_q  <= clk_oe_d;
         data_oe_q <= data_oe_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         error_q   <= error_d;
      end
   end

   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;
   assign busy        = busy_q;
   assign tx_done     = done_q;
   assign tx_error    = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: drives ps2_host_tx against a behavioural PS/2 device.
// The device model clocks the bus, samples the bits the host presents and
// answers with an ACK or a NACK. A reference model, built from the framing
// rules, gives the expected bits and the expected outcome.
module tb_ps2_host_tx;

   localparam int unsigned INH = 500;
   localparam int unsigned TO  = 1000;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tx_start = 1'b0;
   logic [7:0] tx_data = '0;
   logic       dev_clk_low = 1'b0;
   logic       dev_data_low = 1'b0;
   logic       ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_error;
   logic       ps2_clk_line, ps2_data_line;

   // Both lines are open-collector: each is high unless the host or the
   // device pulls it low.
   assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
      .clk         (clk),
      .rst         (rst),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .ps2_clk_in  (ps2_clk_line),
      .ps2_data_in (ps2_data_line),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe),
      .busy        (busy),
      .tx_done     (tx_done),
      .tx_error    (tx_error)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Bus monitor, sampled on the falling edge of clk.
   int   inh_run = 0, inh_both = 0, last_inh_len = 0, last_inh_both = 0;
   logic inh_last_data = 1'b0, last_inh_end_data = 1'b0, clk_oe_prev = 1'b0;
   int   done_cnt = 0, err_cnt = 0, both_cnt = 0, oe_viol = 0;
   int   rel_cyc = 0, err_cyc = 0, rel_events = 0;

   always @(negedge clk) begin
      if (ps2_clk_oe) begin
         inh_run++;
         if (ps2_data_oe) inh_both++;
         inh_last_data = ps2_data_oe;
      end else if (clk_oe_prev) begin
         last_inh_len      = inh_run;
         last_inh_both     = inh_both;
         last_inh_end_data = inh_last_data;
         inh_run  = 0;
         inh_both = 0;
         rel_cyc  = cyc;
         rel_events++;
      end
      if (tx_done) done_cnt++;
      if (tx_error) begin
         err_cnt++;
         err_cyc = cyc;
      end
      if (tx_done && tx_error) both_cnt++;
      if ((ps2_clk_oe || ps2_data_oe) && !busy) oe_viol++;
      clk_oe_prev = ps2_clk_oe;
   end

   // Device model. It waits for request-to-send, then gives 11 clock
   // pulses with half period h. bits[0] is the start bit; bits[k] is the
   // data line sampled at rising edge k. rst_after > 0 asserts reset after
   // rising edge rst_after and ends the transfer. poke_after > 0 pulses
   // tx_start with 0x00 after that rising edge.
   task automatic device_xfer(input int h, input bit ack, input int rst_after,
                              input int poke_after, output logic [10:0] bits,
                              output bit started);
      bits    = '0;
      started = 1'b0;
      for (int i = 0; i < int'(INH) + 200 && !started; i++) begin
         @(negedge clk);
         if (!ps2_clk_oe && ps2_data_oe && busy) started = 1'b1;
      end
      if (!started) return;
      repeat (20) @(negedge clk);
      bits[0] = ps2_data_line;
      for (int k = 1; k <= 11; k++) begin
         dev_clk_low = 1'b1;
         repeat (h) @(negedge clk);
         dev_clk_low = 1'b0;
         if (k <= 10) bits[k] = ps2_data_line;
         if (k == rst_after) begin
            #2 rst = 1'b0;
            #1;
            chk("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
            chk("rst_data_oe", 32'(ps2_data_oe), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            repeat (5) @(negedge clk);
            rst = 1'b1;
            return;
         end
         if (k == poke_after) begin
            tx_data  = 8'h00;
            tx_start = 1'b1;
            @(negedge clk);
            tx_start = 1'b0;
            repeat (h - 1) @(negedge clk);
         end else if (k == 10 && ack) begin
            repeat (h / 2) @(negedge clk);
            dev_data_low = 1'b1;
            repeat (h - h / 2) @(negedge clk);
         end else if (k == 11) begin
            repeat (h / 2) @(negedge clk);
            dev_data_low = 1'b0;
         end else begin
            repeat (h) @(negedge clk);
         end
      end
   endtask

   // Reference framing: start 0, D0..D7 LSB first, odd parity, stop 1.
   function automatic logic [10:0] frame_of(input logic [7:0] d);
      logic [10:0] f;
      int ones;
      ones = 0;
      f = '0;
      for (int i = 0; i < 8; i++) begin
         f[i + 1] = d[i];
         if (d[i]) ones++;
      end
      f[9]  = (ones % 2 == 0);
      f[10] = 1'b1;
      return f;
   endfunction

   task automatic start_req(input logic [7:0] d);
      @(negedge clk);
      tx_data  = d;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
   endtask

   task automatic run_xfer(input string nm, input logic [7:0] d, input int h,
                           input bit ack, input int poke_after);
      int d0, e0;
      logic [10:0] bits;
      bit started;
      d0 = done_cnt;
      e0 = err_cnt;
      start_req(d);
      chk({nm, "_busy_on"}, 32'(busy), 32'd1);
      device_xfer(h, ack, 0, poke_after, bits, started);
      chk({nm, "_rts_seen"}, 32'(started), 32'd1);
      chk({nm, "_inhibit_len"}, 32'(last_inh_len), 32'(INH));
      chk({nm, "_start_cycles"}, 32'(last_inh_both), 32'd1);
      chk({nm, "_start_last"}, 32'(last_inh_end_data), 32'd1);
      chk({nm, "_frame"}, 32'(bits), 32'(frame_of(d)));
      for (int i = 0; i < 200 && done_cnt == d0 && err_cnt == e0; i++) @(negedge clk);
      repeat (10) @(negedge clk);
      chk({nm, "_done"}, 32'(done_cnt - d0), ack ? 32'd1 : 32'd0);
      chk({nm, "_error"}, 32'(err_cnt - e0), ack ? 32'd0 : 32'd1);
      chk({nm, "_busy_off"}, 32'(busy), 32'd0);
      chk({nm, "_oe_idle"}, 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, e0, r0, delta;
      logic [10:0] bits;
      bit started;
      repeat (5) @(negedge clk);
      chk("reset_outputs", 32'({ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_error}), 32'd0);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      chk("idle_after_reset", 32'({ps2_clk_oe, ps2_data_oe, busy}), 32'd0);

      run_xfer("f4_ack", 8'hF4, 40, 1'b1, 0);
      run_xfer("ff_ack", 8'hFF, 45, 1'b1, 0);
      run_xfer("nack", 8'h3C, 35, 1'b0, 0);
      run_xfer("busy_ignore", 8'hF4, 40, 1'b1, 3);

      // The device never clocks after request-to-send.
      e0 = err_cnt;
      d0 = done_cnt;
      r0 = rel_events;
      start_req(8'hA5);
      for (int i = 0; i < int'(INH) + 50 && rel_events == r0; i++) @(negedge clk);
      chk("to_release", 32'(rel_events - r0), 32'd1);
      for (int i = 0; i < int'(TO) + 50 && err_cnt == e0; i++) @(negedge clk);
      delta = err_cyc - rel_cyc;
      chk("to_error", 32'(err_cnt - e0), 32'd1);
      chk("to_latency_ok", 32'(delta >= int'(TO) && delta <= int'(TO) + 2), 32'd1);
      chk("to_no_done", 32'(done_cnt - d0), 32'd0);
      chk("to_lines", 32'({ps2_clk_oe, ps2_data_oe, busy}), 32'd0);

      // Reset after the 4th data bit, then a clean transfer.
      e0 = err_cnt;
      d0 = done_cnt;
      start_req(8'hF4);
      device_xfer(40, 1'b1, 4, 0, bits, started);
      chk("rst_started", 32'(started), 32'd1);
      repeat (30) @(negedge clk);
      chk("rst_no_pulses", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
      chk("rst_idle", 32'({ps2_clk_oe, ps2_data_oe, busy}), 32'd0);
      run_xfer("after_rst", 8'h55, 40, 1'b1, 0);

      for (int n = 0; n < 8; n++) begin
         logic [7:0] d;
         int h;
         bit ack;
         d   = 8'($urandom);
         h   = int'($urandom_range(30, 60));
         ack = ($urandom_range(0, 3) != 0);
         run_xfer($sformatf("rand%0d", n), d, h, ack, 0);
      end

      chk("never_both_pulses", 32'(both_cnt), 32'd0);
      chk("oe_only_when_busy", 32'(oe_viol), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte to the mouse, e.g. 0xF4 (enable data reporting) or 0xFF (reset).
- Sits beside the receive path and shares the ps2_clk/ps2_data open-collector lines. The top level holds the receiver off while busy=1.
- Performs the full inhibit, request-to-send, clocked bit transfer and acknowledge sequence.
- Reports done or error to the command controller.

Parameters:
- INHIBIT_CYCLES, 5000: clk cycles ps2_clk is held low before request-to-send (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000: max clk cycles allowed between successive device clock falling edges, and from clock release to the first edge (15 ms at 50 MHz).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- tx_start  in  1  one-cycle request; sampled only when busy=0
- tx_data  in  8  command byte; latched when tx_start is accepted
- ps2_clk_in  in  1  raw PS/2 clock line, asynchronous
- ps2_data_in  in  1  raw PS/2 data line, asynchronous
- ps2_clk_oe  out  1  1 = drive PS/2 clock low; 0 = release
- ps2_data_oe  out  1  1 = drive PS/2 data low; 0 = release
- busy  out  1  transaction in progress
- tx_done  out  1  one-cycle pulse: byte acknowledged, bus idle
- tx_error  out  1  one-cycle pulse: NACK or timeout

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; ps2_clk_oe=0, ps2_data_oe=0, busy=0, tx_done=0, tx_error=0.
  - Shift register, bit counter and timer are all cleared.
  - Reset mid-transaction releases both lines immediately. No done or error pulse is produced.
- Input conditioning:
  - ps2_clk_in and ps2_data_in each pass through a 2-FF synchronizer.
  - A falling edge (fe) is synchronized clock 1 then 0, one-cycle wide.
  - Edge detection adds 2-3 clk cycles of latency; this is acceptable given the 10-16.7 kHz PS/2 clock.
- Accept:
  - In IDLE, tx_start=1 latches tx_data and computes odd parity, parity = ~^tx_data.
  - busy=1 from the next cycle.
  - tx_start while busy=1 is ignored.
- States:
  - IDLE -> INHIBIT on accept.
  - INHIBIT: ps2_clk_oe=1 for INHIBIT_CYCLES cycles. ps2_data_oe=1 in the final cycle (start bit 0). Then -> RTS.
  - RTS: ps2_clk_oe=0, ps2_data_oe=1; timer restarts. On fe -> DATA with bit index 0, driving ps2_data_oe=~tx_data[0].
  - DATA: each fe advances the index 1..7 and drives ps2_data_oe=~tx_data[i]. The fe after D7 -> PARITY, driving ps2_data_oe=~parity.
  - PARITY: on fe -> STOP; ps2_data_oe=0 (stop bit 1, line released).
  - STOP: on fe (11th edge), sample synchronized ps2_data_in. 0 -> WAIT_IDLE (ACK). 1 -> ERROR (NACK).
  - WAIT_IDLE: wait until synchronized clock=1 and data=1 are both seen in the same cycle. Then tx_done=1 for one cycle and -> IDLE; busy=0 in that same cycle.
  - ERROR: release both lines, tx_error=1 for one cycle, busy=0, -> IDLE.
- Timeout:
  - In RTS, DATA, PARITY, STOP and WAIT_IDLE, the timer counts clk cycles and reloads to 0 on every fe.
  - Reaching TIMEOUT_CYCLES -> ERROR.
- Ownership:
  - ps2_clk_oe is asserted only in INHIBIT.
  - ps2_data_oe is asserted only from the last INHIBIT cycle through PARITY, and only where the bit value is 0.
- Output timing: ps2_*_oe are registered outputs; no combinational path from inputs.
- Concurrency: tx_done and tx_error are mutually exclusive and never both 1.

Test Plan:
- tx_data=0xF4, device model clocks at 12.5 kHz and ACKs. Required:
  - ps2_clk_oe=1 for exactly 5000 cycles; start bit 0.
  - Bits presented on successive falling edges: 0,0,1,0,1,1,1,1; parity=0; stop=1.
  - One tx_done pulse, busy low afterwards.
- tx_data=0xFF with the device ACKing. Required: parity bit=1 observed; tx_done pulse.
- Device holds data high on the 11th edge (NACK). Required: tx_error pulse, no tx_done, both oe=0, busy=0.
- Device never clocks after RTS. Required: tx_error exactly TIMEOUT_CYCLES (+2 sync) after clock release; ps2_data_oe released.
- rst=0 asserted after the 4th data bit, then released. Required: both oe drop asynchronously, no pulses. A new tx_start=0x55 then completes with tx_done.
- tx_start pulsed again with tx_data=0x00 during a 0xF4 transfer. Required: ignored; the wire shows 0xF4, and a single tx_done pulse.
